// File: rtl/jtcontra_layer_pkg.sv
// Shared constants and helpers for the Contra layer mixer and its palette.
package jtcontra_layer_pkg;

  localparam logic [3:0]  TRANSP_MASK   = 4'hF;
  localparam int unsigned PIPE_DEPTH    = 3;
  // Rank k holds layer k; slices of this cover 2..4 layers
  localparam logic [7:0]  PRIO_IDENTITY = 8'b11_10_01_00;

  // Palette byte-address width: layer id bits + pixel bits + byte select
  function automatic int unsigned palaw(input int unsigned layers, input int unsigned pxlw);
    int unsigned idw;
    idw = $clog2(layers);
    return idw + pxlw + 32'd1;
  endfunction

endpackage

// File: rtl/jtcontra_layer_pal.sv
// Palette RAM: CPU byte port (read-before-write) and 16-bit video read port.
module jtcontra_layer_pal #(
  parameter int unsigned AW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_cpu_cs,
  input  logic          i_cpu_rnw,
  input  logic [AW-1:0] i_cpu_addr,
  input  logic [7:0]    i_cpu_din,
  output logic [7:0]    o_cpu_dout,
  input  logic          i_vid_en,
  input  logic [AW-2:0] i_vid_addr,
  output logic [15:0]   o_vid_data
);

  localparam int unsigned DEPTH = 1 << (AW - 1);

  logic [7:0]    r_lo [DEPTH];
  logic [7:0]    r_hi [DEPTH];
  logic [AW-2:0] w_cpu_idx;

  assign w_cpu_idx = i_cpu_addr[AW-1:1];

  // Storage carries no reset so contents survive rst
  always_ff @(posedge clk) begin
    if (i_cpu_cs && !i_cpu_rnw) begin
      if (i_cpu_addr[0]) r_hi[w_cpu_idx] <= i_cpu_din;
      else               r_lo[w_cpu_idx] <= i_cpu_din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_cpu_dout <= 8'd0;
    end else if (i_cpu_cs && i_cpu_rnw) begin
      o_cpu_dout <= i_cpu_addr[0] ? r_hi[w_cpu_idx] : r_lo[w_cpu_idx];
    end
  end

  // Video read sees the pre-write word when the CPU hits the same entry
  always_ff @(posedge clk) begin
    if (rst) begin
      o_vid_data <= 16'd0;
    end else if (i_vid_en) begin
      o_vid_data <= {r_hi[i_vid_addr], r_lo[i_vid_addr]};
    end
  end

endmodule

// File: rtl/jtcontra_layer_mux.sv
// Layer mixer: frontmost opaque layer by programmable priority, palette lookup, blanked RGB.
module jtcontra_layer_mux
  import jtcontra_layer_pkg::*;
#(
  parameter int unsigned LAYERS = 2,
  parameter int unsigned PXLW   = 7,
  parameter int unsigned COLW   = 5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           pxl_cen,
  input  logic                           LHBL,
  input  logic                           LVBL,
  input  logic [LAYERS*PXLW-1:0]         layer_pxl,
  input  logic [LAYERS-1:0]              gfx_en,
  input  logic [2*LAYERS-1:0]            prio_order,
  input  logic                           prio_we,
  input  logic                           pal_cs,
  input  logic                           cpu_rnw,
  input  logic [palaw(LAYERS, PXLW)-1:0] cpu_addr,
  input  logic [7:0]                     cpu_dout,
  output logic [7:0]                     pal_dout,
  output logic [COLW-1:0]                red,
  output logic [COLW-1:0]                green,
  output logic [COLW-1:0]                blue,
  output logic                           LHBL_dly,
  output logic                           LVBL_dly
);

  localparam int unsigned PALAW = palaw(LAYERS, PXLW);
  localparam int unsigned IDW   = $clog2(LAYERS);
  localparam int unsigned IDXW  = IDW + PXLW;
  localparam int unsigned PW    = 2 * LAYERS;

  // 5-bit palette component to COLW by repeating from the MSB down
  function automatic logic [COLW-1:0] expand5(input logic [4:0] c);
    logic [14:0] rep;
    rep = {c, c, c};
    return rep[14 -: COLW];
  endfunction

  logic [PW-1:0]   r_prio_pend;
  logic [PW-1:0]   r_prio_act;
  logic            r_lvbl_last;
  logic            w_vb_fall;

  assign w_vb_fall = r_lvbl_last & ~LVBL;

  // Pending order is promoted only at the start of vertical blank
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio_pend <= PRIO_IDENTITY[PW-1:0];
      r_prio_act  <= PRIO_IDENTITY[PW-1:0];
      r_lvbl_last <= 1'b0;
    end else begin
      r_lvbl_last <= LVBL;
      if (prio_we)   r_prio_pend <= prio_order;
      if (w_vb_fall) r_prio_act  <= prio_we ? prio_order : r_prio_pend;
    end
  end

  logic [PXLW-1:0]   w_lpx     [LAYERS];
  logic [1:0]        w_rank_id [LAYERS];
  logic [LAYERS-1:0] w_opq;

  for (genvar g = 0; g < LAYERS; g++) begin : g_lane
    assign w_lpx[g]     = layer_pxl[g*PXLW +: PXLW];
    assign w_opq[g]     = gfx_en[g] & ((w_lpx[g][3:0] & TRANSP_MASK) != 4'd0);
    assign w_rank_id[g] = r_prio_act[2*g +: 2];
  end

  logic            w_found;
  logic [IDW-1:0]  w_win_id;
  logic [PXLW-1:0] w_win_pxl;

  // Backdrop first, then let the first opaque rank override it
  always_comb begin
    w_found   = 1'b0;
    w_win_id  = IDW'(w_rank_id[LAYERS-1]);
    w_win_pxl = '0;
    for (int n = 0; n < LAYERS; n++) begin
      if (w_rank_id[LAYERS-1] == 2'(n)) w_win_pxl = w_lpx[IDW'(n)];
    end
    for (int k = 0; k < LAYERS; k++) begin
      for (int n = 0; n < LAYERS; n++) begin
        if (!w_found && (w_rank_id[IDW'(k)] == 2'(n)) && w_opq[IDW'(n)]) begin
          w_found   = 1'b1;
          w_win_id  = IDW'(n);
          w_win_pxl = w_lpx[IDW'(n)];
        end
      end
    end
  end

  logic [IDXW-1:0]       r_s1_idx;
  logic [PIPE_DEPTH-1:0] r_hbl_sr;
  logic [PIPE_DEPTH-1:0] r_vbl_sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_idx <= '0;
      r_hbl_sr <= '0;
      r_vbl_sr <= '0;
    end else if (pxl_cen) begin
      r_s1_idx <= {w_win_id, w_win_pxl};
      r_hbl_sr <= {r_hbl_sr[PIPE_DEPTH-2:0], LHBL};
      r_vbl_sr <= {r_vbl_sr[PIPE_DEPTH-2:0], LVBL};
    end
  end

  assign LHBL_dly = r_hbl_sr[PIPE_DEPTH-1];
  assign LVBL_dly = r_vbl_sr[PIPE_DEPTH-1];

  logic [15:0] w_vid_data;
  logic        w_unused_msb;

  assign w_unused_msb = w_vid_data[15];

  jtcontra_layer_pal #(
    .AW (PALAW)
  ) u_pal (
    .clk        (clk),
    .rst        (rst),
    .i_cpu_cs   (pal_cs),
    .i_cpu_rnw  (cpu_rnw),
    .i_cpu_addr (cpu_addr),
    .i_cpu_din  (cpu_dout),
    .o_cpu_dout (pal_dout),
    .i_vid_en   (pxl_cen),
    .i_vid_addr (r_s1_idx),
    .o_vid_data (w_vid_data)
  );

  // Colour is forced black while the matching delayed blanking is active
  always_ff @(posedge clk) begin
    if (rst) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else if (pxl_cen) begin
      if (r_hbl_sr[PIPE_DEPTH-2] & r_vbl_sr[PIPE_DEPTH-2]) begin
        red   <= expand5(w_vid_data[4:0]);
        green <= expand5(w_vid_data[9:5]);
        blue  <= expand5(w_vid_data[14:10]);
      end else begin
        red   <= '0;
        green <= '0;
        blue  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_jtcontra_layer_mux.sv
// Directed bench for jtcontra_layer_mux (2 layers) with a cycle-level reference model.
module tb_jtcontra_layer_mux;

  logic        clk;
  logic        rst;
  logic        pxl_cen;
  logic        LHBL, LVBL;
  logic [13:0] layer_pxl;
  logic [1:0]  gfx_en;
  logic [3:0]  prio_order;
  logic        prio_we;
  logic        pal_cs, cpu_rnw;
  logic [8:0]  cpu_addr;
  logic [7:0]  cpu_dout;
  logic [7:0]  pal_dout;
  logic [4:0]  red, green, blue;
  logic        LHBL_dly, LVBL_dly;

  int tests = 0;
  int fails = 0;

  jtcontra_layer_mux dut (
    .clk        (clk),
    .rst        (rst),
    .pxl_cen    (pxl_cen),
    .LHBL       (LHBL),
    .LVBL       (LVBL),
    .layer_pxl  (layer_pxl),
    .gfx_en     (gfx_en),
    .prio_order (prio_order),
    .prio_we    (prio_we),
    .pal_cs     (pal_cs),
    .cpu_rnw    (cpu_rnw),
    .cpu_addr   (cpu_addr),
    .cpu_dout   (cpu_dout),
    .pal_dout   (pal_dout),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .LHBL_dly   (LHBL_dly),
    .LVBL_dly   (LVBL_dly)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state
  logic [7:0]  pal_m [512];
  logic [3:0]  m_pend, m_act;
  logic        m_vlast, m_live;
  int          m_idx1;
  logic [15:0] m_data2;
  logic [1:0]  m_bl1, m_bl2;
  logic [4:0]  e_r, e_g, e_b;
  logic        e_hb, e_vb;
  logic [7:0]  e_dout;

  // Palette index of the visible pixel: first opaque rank, else rank-1 raw pixel
  function automatic int pick(input logic [3:0] order, input logic [13:0] px, input logic [1:0] en);
    int id;
    logic [6:0] p;
    for (int k = 0; k < 2; k++) begin
      id = int'(order[2*k +: 2]);
      if (id < 2) begin
        p = px[id*7 +: 7];
        if (en[id] && p[3:0] != 4'd0) return id * 128 + int'(p);
      end
    end
    id = int'(order[3:2]);
    p  = (id < 2) ? px[id*7 +: 7] : 7'd0;
    return (id % 2) * 128 + int'(p);
  endfunction

  // Model update on every clk, then compare just after the edge
  initial begin
    m_live = 1'b0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_live  = 1'b1;
        m_pend  = 4'b0100;
        m_act   = 4'b0100;
        m_vlast = 1'b0;
        m_idx1  = 0;
        m_data2 = 16'd0;
        m_bl1   = 2'b00;
        m_bl2   = 2'b00;
        e_r = 5'd0; e_g = 5'd0; e_b = 5'd0;
        e_hb = 1'b0; e_vb = 1'b0;
        e_dout = 8'd0;
      end else if (m_live) begin
        if (pal_cs && cpu_rnw) e_dout = pal_m[cpu_addr];
        if (pxl_cen) begin
          e_hb = m_bl2[0];
          e_vb = m_bl2[1];
          e_r  = (m_bl2 == 2'b11) ? m_data2[4:0]   : 5'd0;
          e_g  = (m_bl2 == 2'b11) ? m_data2[9:5]   : 5'd0;
          e_b  = (m_bl2 == 2'b11) ? m_data2[14:10] : 5'd0;
          m_data2 = {pal_m[2*m_idx1+1], pal_m[2*m_idx1]};
          m_bl2   = m_bl1;
          m_idx1  = pick(m_act, layer_pxl, gfx_en);
          m_bl1   = {LVBL, LHBL};
        end
        if (m_vlast && !LVBL) m_act = prio_we ? prio_order : m_pend;
        if (prio_we) m_pend = prio_order;
        m_vlast = LVBL;
      end
      if (pal_cs && !cpu_rnw) pal_m[cpu_addr] = cpu_dout;
      #1;
      if (m_live) begin
        tests++;
        if ({red, green, blue, LHBL_dly, LVBL_dly} !== {e_r, e_g, e_b, e_hb, e_vb}) begin
          fails++;
          $display("FAIL video @%0t: got rgb=%0d,%0d,%0d hb=%b vb=%b, expected rgb=%0d,%0d,%0d hb=%b vb=%b",
                   $time, red, green, blue, LHBL_dly, LVBL_dly, e_r, e_g, e_b, e_hb, e_vb);
        end
        tests++;
        if (pal_dout !== e_dout) begin
          fails++;
          $display("FAIL pal_dout @%0t: got %h, expected %h", $time, pal_dout, e_dout);
        end
      end
    end
  end

  task automatic lit(input string name, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // One pixel: the next posedge carries pxl_cen; returns at the following negedge
  task automatic pixel();
    @(negedge clk); pxl_cen = 1'b1;
    @(negedge clk); pxl_cen = 1'b0;
  endtask

  task automatic pixels(input int n);
    for (int i = 0; i < n; i++) pixel();
  endtask

  task automatic cpu_wr(input int a, input logic [7:0] d);
    @(negedge clk); pal_cs = 1'b1; cpu_rnw = 1'b0; cpu_addr = 9'(a); cpu_dout = d;
    @(negedge clk); pal_cs = 1'b0; cpu_rnw = 1'b1;
  endtask

  task automatic cpu_rd(input string name, input int a, input logic [7:0] exp);
    @(negedge clk); pal_cs = 1'b1; cpu_rnw = 1'b1; cpu_addr = 9'(a);
    @(negedge clk); lit(name, 16'(pal_dout), 16'(exp));
    @(negedge clk); lit({name, "_hold"}, 16'(pal_dout), 16'(exp));
    pal_cs = 1'b0;
  endtask

  // New order via prio_we at the LVBL falling edge, then back into active video
  task automatic load_prio(input logic [3:0] ord);
    @(negedge clk); LVBL = 1'b0; prio_order = ord; prio_we = 1'b1;
    @(negedge clk); prio_we = 1'b0; LVBL = 1'b1;
  endtask

  function automatic logic [15:0] rgb(input logic [4:0] r, input logic [4:0] g, input logic [4:0] b);
    return 16'({r, g, b});
  endfunction

  initial begin
    rst = 1'b1; pxl_cen = 1'b0; LHBL = 1'b1; LVBL = 1'b1;
    layer_pxl = 14'd0; gfx_en = 2'b11; prio_order = 4'b0100; prio_we = 1'b0;
    pal_cs = 1'b0; cpu_rnw = 1'b1; cpu_addr = 9'd0; cpu_dout = 8'd0;
    pixels(3);
    lit("reset_rgb", rgb(red, green, blue), 16'd0);
    lit("reset_blank", 16'({LHBL_dly, LVBL_dly}), 16'd0);
    lit("reset_dout", 16'(pal_dout), 16'd0);
    @(negedge clk); rst = 1'b0;

    for (int a = 0; a < 512; a++) cpu_wr(a, 8'h00);
    cpu_wr(10, 8'hFF);  cpu_wr(11, 8'h7F);    // entry {0,05} = 7FFF
    cpu_wr(294, 8'h34); cpu_wr(295, 8'h12);   // entry {1,13} = 1234
    cpu_wr(266, 8'hE0); cpu_wr(267, 8'h03);   // entry {1,05} = 03E0

    // Opaque front layer, exact latency
    layer_pxl = {7'h13, 7'h05};
    pixels(2);
    lit("s1_lat2", rgb(red, green, blue), 16'd0);
    pixel();
    lit("s1_white", rgb(red, green, blue), rgb(5'd31, 5'd31, 5'd31));

    // Transparent front layer, then front layer disabled by gfx_en
    layer_pxl = {7'h13, 7'h10};
    pixels(3);
    lit("s2_transp", rgb(red, green, blue), rgb(5'd20, 5'd17, 5'd4));
    layer_pxl = {7'h13, 7'h05}; gfx_en = 2'b10;
    pixels(3);
    lit("s2_gfx_en", rgb(red, green, blue), rgb(5'd20, 5'd17, 5'd4));
    gfx_en = 2'b11;

    // Priority swap only takes effect after the LVBL falling edge
    layer_pxl = {7'h05, 7'h05};
    pixels(3);
    @(negedge clk); prio_order = 4'b0001; prio_we = 1'b1;
    @(negedge clk); prio_we = 1'b0;
    pixels(3);
    lit("s3_midframe", rgb(red, green, blue), rgb(5'd31, 5'd31, 5'd31));
    @(negedge clk); LVBL = 1'b0;
    pixels(3);
    lit("s3_vblank", rgb(red, green, blue), 16'd0);
    lit("s3_lvbl_dly", 16'(LVBL_dly), 16'd0);
    @(negedge clk); LVBL = 1'b1;
    pixels(3);
    lit("s3_swapped", rgb(red, green, blue), rgb(5'd0, 5'd31, 5'd0));

    // prio_we coinciding with the falling edge loads directly
    load_prio(4'b0100);
    pixels(3);
    lit("s3_direct", rgb(red, green, blue), rgb(5'd31, 5'd31, 5'd31));

    // Duplicate ID: layer0 absent, layer1 transparent -> backdrop {1,10}
    load_prio(4'b0101);
    layer_pxl = {7'h10, 7'h05};
    pixels(3);
    lit("dup_backdrop", rgb(red, green, blue), 16'd0);
    load_prio(4'b0100);

    // CPU palette access
    cpu_wr(10, 8'h1F); cpu_wr(11, 8'h00);
    cpu_rd("rd_0a", 10, 8'h1F);
    cpu_rd("rd_0b", 11, 8'h00);
    layer_pxl = {7'h13, 7'h05};
    pixels(3);
    lit("s4_red", rgb(red, green, blue), rgb(5'd31, 5'd0, 5'd0));

    // Same-cycle CPU write and video read of entry 5
    @(negedge clk); pxl_cen = 1'b1; pal_cs = 1'b1; cpu_rnw = 1'b0; cpu_addr = 9'd10; cpu_dout = 8'h00;
    @(negedge clk); pxl_cen = 1'b0; pal_cs = 1'b0; cpu_rnw = 1'b1;
    pixel();
    lit("rw_old", rgb(red, green, blue), rgb(5'd31, 5'd0, 5'd0));
    pixel();
    lit("rw_new", rgb(red, green, blue), 16'd0);
    cpu_wr(10, 8'h1F);

    // Horizontal blanking
    @(negedge clk); LHBL = 1'b0;
    pixels(3);
    lit("s5_hblank", rgb(red, green, blue), 16'd0);
    lit("s5_lhbl_dly", 16'(LHBL_dly), 16'd0);
    @(negedge clk); LHBL = 1'b1;
    pixels(3);
    lit("s5_hactive", rgb(red, green, blue), rgb(5'd31, 5'd0, 5'd0));

    // Reset mid-line clears outputs and restores identity priority
    load_prio(4'b0001);
    layer_pxl = {7'h05, 7'h05};
    pixels(3);
    lit("s5_pre_rst", rgb(red, green, blue), rgb(5'd0, 5'd31, 5'd0));
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    lit("s5_rst_rgb", rgb(red, green, blue), 16'd0);
    lit("s5_rst_blank", 16'({LHBL_dly, LVBL_dly}), 16'd0);
    lit("s5_rst_dout", 16'(pal_dout), 16'd0);
    rst = 1'b0;
    pixels(2);
    lit("s5_resume2", 16'(LHBL_dly), 16'd0);
    pixel();
    lit("s5_resume3", rgb(red, green, blue), rgb(5'd31, 5'd0, 5'd0));
    lit("s5_resume_hb", 16'(LHBL_dly), 16'd1);

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
